// File: rtl/chg_disp.sv
// Change dispenser: queues quarter-change requests from the vending
// controller, pulses the coin-ejector solenoid one quarter at a time,
// tracks hopper inventory and reports change it could not pay.
module chg_disp #(
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HOPPER_MAX = 63,
  parameter int LOW_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_req,
  input  logic [2:0] num_chg,
  input  logic       refill,
  input  logic [5:0] refill_cnt,
  output logic       eject,
  output logic       busy,
  output logic       done,
  output logic       req_drop,
  output logic [5:0] hopper_cnt,
  output logic       low_chg,
  output logic       short_err,
  output logic [2:0] short_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_SHORT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       remaining_q, remaining_d;
  logic [5:0]       hopper_q, hopper_d;
  logic [2:0]       short_cnt_q, short_cnt_d;
  logic             req_drop_q, req_drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       mem [FIFO_DEPTH];

  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       dec;
  logic [7:0] hop_sum;

  // Full is judged on the registered count, before any same-cycle pop.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = disp_req && (num_chg != 3'd0) && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  // Request FIFO pointer/occupancy bookkeeping and overflow flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    req_drop_d = disp_req && (num_chg != 3'd0) && fifo_full;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Dispense sequencer: pop a request, pulse/gap per quarter, short or finish.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    short_cnt_d = short_cnt_q;
    dec         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pop) begin
          remaining_d = mem[rd_ptr_q];
          state_d     = (hopper_q != 6'd0) ? ST_PULSE : ST_SHORT;
        end
      end
      ST_PULSE: begin
        if (timer_q == TMR_W'(PULSE_CYC - 1)) begin
          dec         = 1'b1;
          remaining_d = remaining_q - 3'd1;
          timer_d     = '0;
          state_d     = ST_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == TMR_W'(GAP_CYC - 1)) begin
          timer_d = '0;
          if (remaining_q == 3'd0)    state_d = ST_DONE;
          else if (hopper_q == 6'd0)  state_d = ST_SHORT;
          else                        state_d = ST_PULSE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SHORT: begin
        short_cnt_d = remaining_q;
        remaining_d = 3'd0;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Hopper inventory: refill and decrement both apply, widened then saturated.
  always_comb begin
    hop_sum  = {2'b00, hopper_q} + (refill ? {2'b00, refill_cnt} : 8'd0) - {7'd0, dec};
    hopper_d = (hop_sum > 8'(HOPPER_MAX)) ? 6'(HOPPER_MAX) : hop_sum[5:0];
  end

  // State registers with synchronous reset; reset aborts any dispense at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= 3'd0;
      hopper_q    <= 6'd0;
      short_cnt_q <= 3'd0;
      req_drop_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      hopper_q    <= hopper_d;
      short_cnt_q <= short_cnt_d;
      req_drop_q  <= req_drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count/pointers define validity, so stale entries are never read.
    if (push) mem[wr_ptr_q] <= num_chg;
  end

  assign eject      = (state_q == ST_PULSE);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign done       = (state_q == ST_DONE);
  assign short_err  = (state_q == ST_SHORT);
  assign req_drop   = req_drop_q;
  assign hopper_cnt = hopper_q;
  assign low_chg    = (hopper_q < 6'(LOW_THRESH));
  assign short_cnt  = short_cnt_q;

endmodule

// File: tb/tb_chg_disp.sv
// Testbench for chg_disp: vector table, directed multi-cycle scenarios,
// then randomized traffic against a quarter-slot reference model.
module tb_chg_disp;

  localparam int P   = 4;
  localparam int G   = 2;
  localparam int PER = P + G;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       disp_req;
  logic [2:0] num_chg;
  logic       refill;
  logic [5:0] refill_cnt;
  logic       eject, busy, done, req_drop, low_chg, short_err;
  logic [5:0] hopper_cnt;
  logic [2:0] short_cnt;

  int checks = 0;
  int errors = 0;

  chg_disp #(
    .PULSE_CYC(P), .GAP_CYC(G), .FIFO_DEPTH(DEPTH), .HOPPER_MAX(63), .LOW_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .num_chg(num_chg),
    .refill(refill), .refill_cnt(refill_cnt), .eject(eject), .busy(busy),
    .done(done), .req_drop(req_drop), .hopper_cnt(hopper_cnt), .low_chg(low_chg),
    .short_err(short_err), .short_cnt(short_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle.
  int   ej_rises = 0, done_n = 0, short_n = 0, drop_n = 0;
  logic ej_prev  = 1'b0;
  always @(negedge clk) begin
    if (eject === 1'b1 && ej_prev !== 1'b1) ej_rises++;
    if (done === 1'b1)      done_n++;
    if (short_err === 1'b1) short_n++;
    if (req_drop === 1'b1)  drop_n++;
    ej_prev = eject;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; disp_req = 1'b0; num_chg = '0; refill = 1'b0; refill_cnt = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic refill_by(input int n);
    refill = 1'b1; refill_cnt = 6'(n);
    cyc();
    refill = 1'b0; refill_cnt = '0;
  endtask

  task automatic request(input int n);
    disp_req = 1'b1; num_chg = 3'(n);
    cyc();
    disp_req = 1'b0; num_chg = '0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      cyc();
      n++;
    end
    check({nm, "_idle_timeout"}, 32'(n >= max_cyc), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, dr;
    logic [2:0] num;
    logic       rf;
    logic [5:0] rc;
    logic [10:0] exp;  // {eject, busy, done, short_err, low_chg, hopper[5:0]}
  } vec_t;

  function automatic vec_t mk(input logic r, input logic d, input int n, input logic f, input int c,
                              input logic ej, input logic bz, input logic dn, input logic se,
                              input logic lc, input int hop);
    vec_t v;
    v.rst = r; v.dr = d; v.num = 3'(n); v.rf = f; v.rc = 6'(c);
    v.exp = {ej, bz, dn, se, lc, 6'(hop)};
    return v;
  endfunction

  vec_t vec [24];

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_SHORT = 2, PH_DONE = 3;
  int m_q[$];
  int m_ph, m_t, m_left, m_hop, m_sc;
  bit m_drop;

  task automatic model_step(input bit r, input bit dr, input int n, input bit rf, input int rc);
    bit full;
    int dec, off;
    if (r) begin
      m_q.delete(); m_ph = PH_IDLE; m_t = 0; m_left = 0; m_hop = 0; m_sc = 0; m_drop = 0;
      return;
    end
    full = (m_q.size() == DEPTH);
    dec  = 0;
    case (m_ph)
      PH_IDLE: if (m_q.size() != 0) begin
        m_left = m_q.pop_front();
        m_t    = 0;
        m_ph   = (m_hop > 0) ? PH_RUN : PH_SHORT;
      end
      PH_RUN: begin
        off = m_t % PER;
        if (off == P - 1) begin dec = 1; m_left--; end
        if (off == PER - 1) begin
          if (m_left == 0)     m_ph = PH_DONE;
          else if (m_hop == 0) m_ph = PH_SHORT;
          else                 m_t++;
        end else m_t++;
      end
      PH_SHORT: begin m_sc = m_left; m_left = 0; m_ph = PH_DONE; end
      default:  m_ph = PH_IDLE;
    endcase
    m_drop = dr && n != 0 && full;
    if (dr && n != 0 && !full) m_q.push_back(n);
    m_hop = m_hop + (rf ? rc : 0) - dec;
    if (m_hop > 63) m_hop = 63;
  endtask

  function automatic logic [14:0] model_out();
    logic ej;
    ej = (m_ph == PH_RUN) && ((m_t % PER) < P);
    return {ej, (m_ph != PH_IDLE) || (m_q.size() != 0), m_ph == PH_DONE, m_ph == PH_SHORT,
            m_drop, m_hop < 4, 3'(m_sc), 6'(m_hop)};
  endfunction

  int b_ej, b_dn, b_sh, b_dr;
  task automatic snap();
    b_ej = ej_rises; b_dn = done_n; b_sh = short_n; b_dr = drop_n;
  endtask

  initial begin
    int n;
    rst = 1'b1; disp_req = 1'b0; num_chg = '0; refill = 1'b0; refill_cnt = '0;
    cyc();

    // Reset, refill to 10, then pay 2 quarters (request in row 7 = cycle k).
    for (int i = 0; i < 5; i++) vec[i] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    vec[5] = mk(0, 0, 0, 1, 10, 0, 0, 0, 0, 1, 0);
    vec[6] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10);
    vec[7] = mk(0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 10);
    vec[8] = mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 10);
    for (int i = 9;  i <= 12; i++) vec[i] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 10);
    for (int i = 13; i <= 14; i++) vec[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9);
    for (int i = 15; i <= 18; i++) vec[i] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 9);
    for (int i = 19; i <= 20; i++) vec[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8);
    vec[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8);
    vec[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    vec[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);

    for (int i = 0; i < 24; i++) begin
      rst = vec[i].rst; disp_req = vec[i].dr; num_chg = vec[i].num;
      refill = vec[i].rf; refill_cnt = vec[i].rc;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({eject, busy, done, short_err, low_chg, hopper_cnt}),
            32'(vec[i].exp));
      if (i < 5) check($sformatf("vec%0d_rst_pulses", i), 32'({req_drop, short_cnt}), 32'd0);
      cyc();
    end
    disp_req = 1'b0; num_chg = '0; refill = 1'b0; refill_cnt = '0;

    // Queueing and overflow.
    do_reset(); refill_by(40); snap();
    for (int i = 0; i < 5; i++) request(1);
    wait_idle(200, "s3a");
    check("s3a_done", 32'(done_n - b_dn), 32'd5);
    check("s3a_drop", 32'(drop_n - b_dr), 32'd0);
    check("s3a_hop", 32'(hopper_cnt), 32'd35);
    snap();
    request(1);
    n = 0;
    while (eject !== 1'b1 && n < 10) begin cyc(); n++; end
    check("s3b_eject_timeout", 32'(n >= 10), 32'd0);
    for (int i = 0; i < 5; i++) request(3);
    check("s3b_drop_now", 32'(req_drop), 32'd1);
    cyc();
    check("s3b_drop_clear", 32'(req_drop), 32'd0);
    wait_idle(400, "s3b");
    check("s3b_drop", 32'(drop_n - b_dr), 32'd1);
    check("s3b_done", 32'(done_n - b_dn), 32'd5);
    check("s3b_hop", 32'(hopper_cnt), 32'd22);

    // Short: one quarter in hopper, three owed.
    do_reset(); refill_by(1); snap();
    request(3);
    wait_idle(100, "s4");
    check("s4_ejects", 32'(ej_rises - b_ej), 32'd1);
    check("s4_short", 32'(short_n - b_sh), 32'd1);
    check("s4_short_cnt", 32'(short_cnt), 32'd2);
    check("s4_done", 32'(done_n - b_dn), 32'd1);
    check("s4_hop_low", 32'({low_chg, hopper_cnt}), 32'h40);

    // Saturation with refill on the decrement cycle.
    do_reset(); refill_by(62);
    request(1);               // now in k+1
    cyc();                    // k+2
    check("s5_eject_start", 32'(eject), 32'd1);
    cyc(); cyc(); cyc();      // k+5, last pulse cycle
    check("s5_eject_last", 32'(eject), 32'd1);
    refill_by(5);             // now k+6
    check("s5_sat", 32'({eject, hopper_cnt}), 32'd63);
    wait_idle(50, "s5a");
    check("s5_sat_hold", 32'(hopper_cnt), 32'd63);

    // Empty hopper: immediate short.
    do_reset(); snap();
    request(1);
    wait_idle(50, "s5b");
    check("s5b_ejects", 32'(ej_rises - b_ej), 32'd0);
    check("s5b_short", 32'({3'(short_n - b_sh), short_cnt}), 32'({3'd1, 3'd1}));

    // Reset during the second pulse.
    do_reset(); refill_by(20); snap();
    request(4);
    n = 0;
    while (ej_rises - b_ej < 2 && n < 40) begin cyc(); n++; end
    check("s6_second_pulse_timeout", 32'(n >= 40), 32'd0);
    check("s6_in_pulse", 32'(eject), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("s6_after_rst", 32'({eject, busy, hopper_cnt}), 32'd0);
    refill_by(10); snap();
    request(2);
    check("s6_lat_k1", 32'(eject), 32'd0);
    cyc();
    check("s6_lat_k2", 32'(eject), 32'd1);
    wait_idle(60, "s6");
    check("s6_ejects", 32'(ej_rises - b_ej), 32'd2);
    check("s6_done_hop", 32'({3'(done_n - b_dn), hopper_cnt}), 32'({3'd1, 6'd8}));
    check("s6_short", 32'(short_n - b_sh), 32'd0);

    // Randomized traffic against the reference model.
    rst = 1'b1; disp_req = 1'b0; num_chg = '0; refill = 1'b0; refill_cnt = '0;
    model_step(1, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 399) == 0);
      disp_req = ($urandom_range(0, 5) == 0);
      num_chg  = 3'($urandom_range(0, 7));
      refill   = ($urandom_range(0, 24) == 0);
      refill_cnt = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
      @(negedge clk);
      check("model", 32'({eject, busy, done, short_err, req_drop, low_chg, short_cnt, hopper_cnt}),
            32'(model_out()));
      @(posedge clk);
      model_step(rst, disp_req, int'(num_chg), refill, int'(refill_cnt));
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
